// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor speed ramp.
// Speed type, channel state encoding, step and clamp functions.
package motor_pkg;

    localparam int SPD_W   = 11;
    localparam int SPD_MAX = 1023;

    typedef logic signed [SPD_W-1:0] spd_t;
    typedef logic signed [SPD_W:0]   wide_t;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        HOLD
    } ramp_st_t;

    // Move cur toward dst by at most stp, never past dst.
    function automatic spd_t step_toward(spd_t cur, spd_t dst, wide_t stp);
        wide_t c;
        wide_t d;
        wide_t n;
        c = wide_t'(cur);
        d = wide_t'(dst);
        if (d > c) begin
            n = c + stp;
            if (n > d) n = d;
        end else begin
            n = c - stp;
            if (n < d) n = d;
        end
        return n[SPD_W-1:0];
    endfunction

    // Both non-zero with opposite signs.
    function automatic logic is_rev(spd_t a, spd_t b);
        return (a != '0) && (b != '0) && (a[SPD_W-1] != b[SPD_W-1]);
    endfunction

    // -1024 has no valid magnitude downstream; pull it in to -1023.
    function automatic spd_t clamp_spd(spd_t v);
        if (v == spd_t'(-SPD_MAX - 1)) return spd_t'(-SPD_MAX);
        return v;
    endfunction

endpackage

// File: rtl/motor_ramp_if.sv
// Command/status bundle between steering logic and the ramp block.
// master drives targets/estop; slave returns speeds and status.
interface motor_ramp_if;
    import motor_pkg::*;

    logic cmd_vld;
    logic cmd_rdy;
    spd_t tgt_lft;
    spd_t tgt_rht;
    logic estop;
    logic estop_clr;
    spd_t lft;
    spd_t rht;
    logic settled;
    logic estop_act;

    modport master (
        output cmd_vld, tgt_lft, tgt_rht, estop, estop_clr,
        input  cmd_rdy, lft, rht, settled, estop_act
    );

    modport slave (
        input  cmd_vld, tgt_lft, tgt_rht, estop, estop_clr,
        output cmd_rdy, lft, rht, settled, estop_act
    );

endinterface

// File: rtl/ramp_chan.sv
// One wheel's slew limiter: IDLE/UP/DOWN/HOLD FSM stepping on tick.
// In: clk, rst, tick, tgt, kill. Out: cur (registered speed), idle.
module ramp_chan
    import motor_pkg::*;
#(
    parameter int STEP        = 8,
    parameter int BRAKE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic kill,
    input  spd_t tgt,
    output spd_t cur,
    output logic idle
);

    localparam int    HW  = $clog2(BRAKE_TICKS + 1);
    localparam wide_t STP = wide_t'(STEP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BRAKE_TICKS - 1);

    ramp_st_t      state_q, state_d;
    spd_t          cur_q, cur_d;
    logic [HW-1:0] hold_q, hold_d;

    spd_t     to_tgt;
    spd_t     to_zero;
    logic     rev;
    logic     same_sgn;
    ramp_st_t dn_st;
    ramp_st_t up_st;

    always_comb begin
        to_tgt   = step_toward(cur_q, tgt, STP);
        to_zero  = step_toward(cur_q, '0, STP);
        rev      = is_rev(cur_q, tgt);
        same_sgn = (cur_q != '0) && (tgt != '0) &&
                   (cur_q[SPD_W-1] == tgt[SPD_W-1]);
        // Where a step toward zero lands us; zero-crossing decided here
        // so a reversal is never lost by arriving at 0 first.
        if (to_zero != '0) dn_st = DOWN;
        else if (rev)      dn_st = HOLD;
        else if (tgt == '0) dn_st = IDLE;
        else               dn_st = UP;
        up_st = (to_tgt == tgt) ? IDLE : UP;
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hold_d  = hold_q;
        if (kill) begin
            state_d = IDLE;
            cur_d   = '0;
            hold_d  = '0;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (cur_q != tgt) begin
                        if (rev || tgt == '0) begin
                            state_d = dn_st;
                            cur_d   = to_zero;
                            hold_d  = '0;
                        end else begin
                            state_d = up_st;
                            cur_d   = to_tgt;
                        end
                    end
                end
                UP: begin
                    if (cur_q == tgt) begin
                        state_d = IDLE;
                    end else if (rev) begin
                        state_d = dn_st;
                        cur_d   = to_zero;
                        hold_d  = '0;
                    end else begin
                        state_d = up_st;
                        cur_d   = to_tgt;
                    end
                end
                DOWN: begin
                    if (same_sgn) begin
                        state_d = up_st;
                        cur_d   = to_tgt;
                    end else begin
                        state_d = dn_st;
                        cur_d   = to_zero;
                        hold_d  = '0;
                    end
                end
                HOLD: begin
                    cur_d = '0;
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = (tgt == '0) ? IDLE : UP;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
        end
    end

    assign cur  = cur_q;
    assign idle = (state_q == IDLE);

endmodule

// File: rtl/motor_ramp.sv
// Dual-wheel slew limiter with reversal brake dwell and latching estop.
// Ports: clk, rst (sync, active-high), bus (motor_ramp_if.slave).
module motor_ramp
    import motor_pkg::*;
#(
    parameter int RAMP_DIV    = 5000,
    parameter int STEP        = 8,
    parameter int BRAKE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    motor_ramp_if.slave bus
);

    localparam int CW = $clog2(RAMP_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          estop_act_q, estop_act_d;
    spd_t          tgt_l_q, tgt_l_d;
    spd_t          tgt_r_q, tgt_r_d;
    logic          settled_q, settled_d;

    logic tick;
    logic accept;
    spd_t cur_l, cur_r;
    logic idle_l, idle_r;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        // estop beats a same-cycle accept
        accept = bus.cmd_vld & ~estop_act_q & ~bus.estop;

        estop_act_d = estop_act_q;
        if (bus.estop)          estop_act_d = 1'b1;
        else if (bus.estop_clr) estop_act_d = 1'b0;

        tgt_l_d = tgt_l_q;
        tgt_r_d = tgt_r_q;
        if (bus.estop) begin
            tgt_l_d = '0;
            tgt_r_d = '0;
        end else if (accept) begin
            tgt_l_d = clamp_spd(bus.tgt_lft);
            tgt_r_d = clamp_spd(bus.tgt_rht);
        end

        settled_d = idle_l & idle_r &
                    (cur_l == tgt_l_q) & (cur_r == tgt_r_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            estop_act_q <= 1'b0;
            tgt_l_q     <= '0;
            tgt_r_q     <= '0;
            settled_q   <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            estop_act_q <= estop_act_d;
            tgt_l_q     <= tgt_l_d;
            tgt_r_q     <= tgt_r_d;
            settled_q   <= settled_d;
        end
    end

    ramp_chan #(
        .STEP        (STEP),
        .BRAKE_TICKS (BRAKE_TICKS)
    ) u_lft (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .kill (bus.estop),
        .tgt  (tgt_l_q),
        .cur  (cur_l),
        .idle (idle_l)
    );

    ramp_chan #(
        .STEP        (STEP),
        .BRAKE_TICKS (BRAKE_TICKS)
    ) u_rht (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .kill (bus.estop),
        .tgt  (tgt_r_q),
        .cur  (cur_r),
        .idle (idle_r)
    );

    assign bus.cmd_rdy   = ~estop_act_q;
    assign bus.lft       = cur_l;
    assign bus.rht       = cur_r;
    assign bus.settled   = settled_q;
    assign bus.estop_act = estop_act_q;

endmodule
